// File: rtl/umi_sync_fifo_if.sv
// UMI channel bundle: valid/ready handshake plus cmd, dstaddr, srcaddr, data.
// master drives the packet and valid; slave drives ready.
interface umi_sync_fifo_if #(
    parameter int DW = 128,
    parameter int AW = 64,
    parameter int CW = 32
);
    logic          valid;
    logic          ready;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;

    modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
    modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_sync_fifo.sv
// Single-clock UMI FIFO with combinational bypass. Define UMI_FIFO_CHAOS_EN to
// enable LFSR-driven random input stalls under chaosmode.
module umi_sync_fifo #(
    parameter int DW    = 128,
    parameter int AW    = 64,
    parameter int CW    = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            bypass,
    input  logic            chaosmode,
    output logic            fifo_full,
    output logic            fifo_empty,
    umi_sync_fifo_if.slave  umi_in,
    umi_sync_fifo_if.master umi_out
);
    localparam int EW   = CW + 2 * AW + DW;
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CNTW-1:0] count_reg;
    logic [EW-1:0]   entry_in;
    logic [EW-1:0]   entry_out;
    logic            stall;
    logic            wr_en;
    logic            rd_en;

`ifdef UMI_FIFO_CHAOS_EN
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) lfsr_reg <= 16'h0001;
        else         lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end

    assign stall = chaosmode & lfsr_reg[0];
`else
    logic unused_chaosmode;
    assign unused_chaosmode = chaosmode;
    assign stall            = 1'b0;
`endif

    assign fifo_full  = (count_reg == CNTW'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    // Ready never looks at umi_out.ready in FIFO mode: a full FIFO refuses input
    // even on a cycle where it is being drained.
    assign umi_in.ready = bypass ? umi_out.ready : (~fifo_full & ~stall);

    assign wr_en = ~bypass & umi_in.valid & ~fifo_full & ~stall;
    assign rd_en = ~bypass & ~fifo_empty & umi_out.ready;

    assign entry_in  = {umi_in.cmd, umi_in.dstaddr, umi_in.srcaddr, umi_in.data};
    assign entry_out = mem[rd_ptr_reg];

    always_comb begin
        if (bypass) begin
            umi_out.valid   = umi_in.valid;
            umi_out.cmd     = umi_in.cmd;
            umi_out.dstaddr = umi_in.dstaddr;
            umi_out.srcaddr = umi_in.srcaddr;
            umi_out.data    = umi_in.data;
        end else begin
            umi_out.valid = ~fifo_empty;
            {umi_out.cmd, umi_out.dstaddr, umi_out.srcaddr, umi_out.data} = entry_out;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= entry_in;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNTW'(1);
                2'b01:   count_reg <= count_reg - CNTW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_umi_sync_fifo.sv
// Directed vectors for a DEPTH=4 FIFO plus sequences on DEPTH=1 and DEPTH=3
// instances covering throughput, wrap, reset and chaos stalls.
module tb_umi_sync_fifo;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic bypass4 = 1'b0, chaos4 = 1'b0, zero = 1'b0;
    logic full4, empty4, full1, empty1, full3, empty3;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    umi_sync_fifo_if in4(), out4(), in1(), out1(), in3(), out3();

    umi_sync_fifo #(.DEPTH(4)) u4 (.clk(clk), .nreset(nreset), .bypass(bypass4), .chaosmode(chaos4),
        .fifo_full(full4), .fifo_empty(empty4), .umi_in(in4), .umi_out(out4));
    umi_sync_fifo #(.DEPTH(1)) u1 (.clk(clk), .nreset(nreset), .bypass(zero), .chaosmode(zero),
        .fifo_full(full1), .fifo_empty(empty1), .umi_in(in1), .umi_out(out1));
    umi_sync_fifo #(.DEPTH(3)) u3 (.clk(clk), .nreset(nreset), .bypass(zero), .chaosmode(zero),
        .fifo_full(full3), .fifo_empty(empty3), .umi_in(in3), .umi_out(out3));

    typedef struct {
        logic        byp;
        logic        iv;
        logic [31:0] cmd;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        e_full;
        logic        e_empty;
        logic        chk;
        logic [31:0] e_cmd;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] mkdata(input logic [31:0] c);
        return {c, ~c, c, ~c};
    endfunction

    task automatic set4(input logic v, input logic [31:0] c);
        in4.valid   = v;
        in4.cmd     = c;
        in4.dstaddr = {c, ~c};
        in4.srcaddr = {~c, c};
        in4.data    = mkdata(c);
    endtask

    task automatic check_head4(input string tag, input logic [31:0] c);
        check({tag, " cmd"}, 128'(out4.cmd), 128'(c));
        check({tag, " dstaddr"}, 128'(out4.dstaddr), 128'({c, ~c}));
        check({tag, " srcaddr"}, 128'(out4.srcaddr), 128'({~c, c}));
        check({tag, " data"}, out4.data, mkdata(c));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] sb_data[$];
        logic [31:0]  sb_cmd[$];
        logic [31:0]  sb4[$];
        logic [127:0] pdata;
        logic [31:0]  pcmd, nxt;
        logic         acc, del;
        int           sent, got, last_cyc, cyc, occ, stalls, max_occ;

        // order: byp iv cmd ordy | e_ov e_ir e_full e_empty chk e_cmd
        vecs[0]  = '{1'b0, 1'b1, 32'h1,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h2,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1};
        vecs[2]  = '{1'b0, 1'b1, 32'h3,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1};
        vecs[3]  = '{1'b0, 1'b1, 32'h4,    1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1};
        vecs[4]  = '{1'b0, 1'b1, 32'h5,    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1};
        vecs[5]  = '{1'b0, 1'b1, 32'h5,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h3};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h6,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h7,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h6};
        vecs[12] = '{1'b0, 1'b1, 32'h8,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h7};
        vecs[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8};
        vecs[14] = '{1'b1, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD};
        vecs[15] = '{1'b1, 1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBEEF};
        vecs[16] = '{1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[17] = '{1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};

        set4(1'b0, 32'h0);
        out4.ready = 1'b0;
        in1.valid = 1'b0; in1.cmd = '0; in1.dstaddr = '0; in1.srcaddr = '0; in1.data = '0;
        out1.ready = 1'b0;
        in3.valid = 1'b0; in3.cmd = '0; in3.dstaddr = '0; in3.srcaddr = '0; in3.data = '0;
        out3.ready = 1'b0;

        // Reset held for 16 cycles
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("rst empty4", 128'(empty4), 128'(1'b1));
        check("rst full4", 128'(full4), 128'(1'b0));
        check("rst out_valid4", 128'(out4.valid), 128'(1'b0));
        check("rst in_ready4", 128'(in4.ready), 128'(1'b1));
        check("rst empty1", 128'(empty1), 128'(1'b1));
        check("rst empty3", 128'(empty3), 128'(1'b1));
        tick();
        nreset = 1'b1;
        tick();

        for (int i = 0; i < 18; i++) begin
            bypass4    = vecs[i].byp;
            out4.ready = vecs[i].ordy;
            set4(vecs[i].iv, vecs[i].cmd);
            @(negedge clk);
            check($sformatf("v%0d out_valid", i), 128'(out4.valid), 128'(vecs[i].e_ov));
            check($sformatf("v%0d in_ready", i), 128'(in4.ready), 128'(vecs[i].e_ir));
            check($sformatf("v%0d full", i), 128'(full4), 128'(vecs[i].e_full));
            check($sformatf("v%0d empty", i), 128'(empty4), 128'(vecs[i].e_empty));
            if (vecs[i].chk) check_head4($sformatf("v%0d", i), vecs[i].e_cmd);
            $display("vec %0d: byp=%0b iv=%0b cmd=%0h ordy=%0b -> ov=%0b ir=%0b full=%0b empty=%0b",
                     i, vecs[i].byp, vecs[i].iv, vecs[i].cmd, vecs[i].ordy,
                     out4.valid, in4.ready, full4, empty4);
            tick();
        end

        // Asynchronous reset mid-operation drops stored packets at once
        set4(1'b1, 32'h11);
        tick();
        set4(1'b1, 32'h12);
        tick();
        set4(1'b0, 32'h0);
        #2;
        check("pre-rst empty4", 128'(empty4), 128'(1'b0));
        nreset = 1'b0;
        #1;
        check("async rst empty4", 128'(empty4), 128'(1'b1));
        check("async rst out_valid4", 128'(out4.valid), 128'(1'b0));
        tick();
        nreset = 1'b1;
        tick();
        check("post rst empty4", 128'(empty4), 128'(1'b1));

        // DEPTH=1: 10 packets with valid and ready held high
        out1.ready = 1'b1;
        in1.valid  = 1'b1;
        in1.cmd    = 32'd0;
        in1.data   = 128'd0;
        sent = 0; got = 0; last_cyc = 0; cyc = 0;
        while (got < 10 && cyc < 100) begin
            @(negedge clk);
            acc = in1.valid & in1.ready;
            if (out1.valid) begin
                check($sformatf("d1 data %0d", got), out1.data, 128'(got));
                check($sformatf("d1 cmd %0d", got), 128'(out1.cmd), 128'(got));
                if (got > 0) check($sformatf("d1 gap %0d", got), 128'(cyc - last_cyc), 128'd2);
                $display("depth1 pkt %0d out at cycle %0d", got, cyc);
                last_cyc = cyc;
                got++;
            end
            tick();
            cyc++;
            if (acc) begin
                sent++;
                if (sent == 10) in1.valid = 1'b0;
                else begin
                    in1.cmd  = 32'(sent);
                    in1.data = 128'(sent);
                end
            end
        end
        check("d1 delivered", 128'(got), 128'd10);
        out1.ready = 1'b0;

        // DEPTH=3: 100 random packets with random valid/ready
        sent = 0; got = 0; cyc = 0; occ = 0; max_occ = 0;
        in3.valid = 1'b0;
        while (got < 100 && cyc < 3000) begin
            if (!in3.valid && sent < 100) begin
                pcmd  = $urandom;
                pdata = {$urandom, $urandom, $urandom, $urandom};
                in3.cmd  = pcmd;
                in3.data = pdata;
                in3.valid = ($urandom_range(0, 3) != 0);
            end
            out3.ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("d3 full", 128'(full3), 128'(occ == 3));
            check("d3 empty", 128'(empty3), 128'(occ == 0));
            acc = in3.valid & in3.ready;
            del = out3.valid & out3.ready;
            if (del) begin
                if (sb_cmd.size() == 0) begin
                    check("d3 unexpected output", 128'd1, 128'd0);
                end else begin
                    check($sformatf("d3 cmd %0d", got), 128'(out3.cmd), 128'(sb_cmd.pop_front()));
                    check($sformatf("d3 data %0d", got), out3.data, sb_data.pop_front());
                    got++;
                end
                occ--;
            end
            tick();
            cyc++;
            if (acc) begin
                sb_cmd.push_back(in3.cmd);
                sb_data.push_back(in3.data);
                sent++;
                occ++;
                in3.valid = 1'b0;
            end
            if (occ > max_occ) max_occ = occ;
        end
        $display("depth3 stream: %0d sent, %0d received in %0d cycles, max occupancy %0d",
                 sent, got, cyc, max_occ);
        check("d3 delivered", 128'(got), 128'd100);
        check("d3 max occupancy", 128'(max_occ <= 3), 128'd1);

        // Chaos mode on the DEPTH=4 instance with the consumer always ready
        chaos4 = 1'b1;
        out4.ready = 1'b1;
        nxt = 32'h100;
        stalls = 0;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            set4(c < 50, nxt);
            @(negedge clk);
            if (!full4 && !in4.ready && in4.valid) stalls++;
            acc = in4.valid & in4.ready;
            if (out4.valid) begin
                if (sb4.size() == 0) check("chaos unexpected output", 128'd1, 128'd0);
                else begin
                    check($sformatf("chaos cmd %0d", got), 128'(out4.cmd), 128'(sb4.pop_front()));
                    got++;
                end
            end
            tick();
            if (acc) begin
                sb4.push_back(nxt);
                nxt++;
            end
        end
        $display("chaos run: %0d accepted, %0d delivered, %0d stall cycles", nxt - 32'h100, got, stalls);
        check("chaos drained", 128'(sb4.size()), 128'd0);
`ifdef UMI_FIFO_CHAOS_EN
        check("chaos stalls seen", 128'(stalls > 0), 128'd1);
`else
        check("no stalls without chaos", 128'(stalls), 128'd0);
`endif
        chaos4 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/umi_sync_fifo.md
# umi_sync_fifo

Single-clock FIFO buffering one UMI channel (cmd, dstaddr, srcaddr, data) between a valid/ready producer and a valid/ready consumer. It sits between a host agent and a UMI device (e.g. memory agent) on either the request or the response path to decouple back-pressure. A bypass control turns it into a combinational wire, and an optional chaos mode injects random input stalls for verification.

## Interface
- DW, 128, data field width
- AW, 64, dstaddr/srcaddr width
- CW, 32, command width
- DEPTH, 4, number of entries; any integer ≥1
- clk  in  1  clock; all state on rising edge
- nreset  in  1  asynchronous active-low reset
- bypass  in  1  1 = combinational pass-through, storage ignored
- chaosmode  in  1  1 = pseudo-random input stalls (only with UMI_FIFO_CHAOS_EN)
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- umi_in_valid  in  1  producer valid
- umi_in_cmd / umi_in_dstaddr / umi_in_srcaddr / umi_in_data  in  CW/AW/AW/DW  input packet
- umi_in_ready  out  1  FIFO accepts packet this cycle
- umi_out_valid  out  1  head packet available
- umi_out_cmd / umi_out_dstaddr / umi_out_srcaddr / umi_out_data  out  CW/AW/AW/DW  head packet
- umi_out_ready  in  1  consumer accepts head packet

## Operation
- Entry = {cmd, dstaddr, srcaddr, data}, CW+2·AW+DW bits, stored verbatim.
- Write on rising edge when umi_in_valid & umi_in_ready (bypass=0): entry at wr_ptr, wr_ptr advances.
- Read on rising edge when umi_out_valid & umi_out_ready (bypass=0): rd_ptr advances.
- Pointers range 0..DEPTH-1, wrap DEPTH-1 → 0 (DEPTH need not be a power of two); count register 0..DEPTH tracks occupancy.
- umi_in_ready = ~fifo_full & ~stall; no combinational path from umi_out_ready to umi_in_ready (full FIFO never accepts, even when reading same cycle).
- umi_out_valid = ~fifo_empty; umi_out_* driven combinationally from entry at rd_ptr.
- Simultaneous read and write (not full, not empty): count unchanged, both pointers advance.
- Order strictly preserved; no packet dropped or duplicated.
- bypass=1: umi_out_valid = umi_in_valid, umi_out_* = umi_in_*, umi_in_ready = umi_out_ready; pointers/count hold; fifo_full/fifo_empty still reflect stored state. Bypass is switched only while the FIFO is empty; otherwise stored entries are retained and drain once bypass returns to 0.
- Storage array is not reset; umi_out_* are don't-care while umi_out_valid=0.

## Timing
- Reset (nreset low, asynchronous): count=0, pointers=0, LFSR=16'h0001; fifo_empty=1, fifo_full=0, umi_out_valid=0, umi_in_ready=1 (bypass=0).
- Latency: packet written at edge N is visible on umi_out_* with umi_out_valid=1 after edge N (one cycle, no fall-through).
- DEPTH=1: full after one write, so sustained throughput is one packet per two cycles.
- Reset mid-operation discards all stored packets immediately; no partial outputs.
- bypass path: zero latency, purely combinational.

## Configuration
- UMI_FIFO_CHAOS_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; stall = chaosmode & lfsr[0], forcing umi_in_ready low that cycle.
- Undefined: no LFSR, stall = 0, chaosmode input ignored.

## Test plan
- Reset: hold nreset low 16 cycles → fifo_empty=1, fifo_full=0, umi_out_valid=0, umi_in_ready=1.
- DEPTH=4, write cmd 0x1..0x4 with umi_out_ready=0 → fifo_full=1, umi_in_ready=0; then umi_out_ready=1 → cmd 0x1,0x2,0x3,0x4 out in order on consecutive cycles, fifo_empty=1 after.
- DEPTH=1, continuous valid and ready, 10 packets (data=i) → all 10 delivered in order, one every 2 cycles.
- Wrap: DEPTH=3, stream 100 random packets with random valid/ready → output sequence identical to input, count never exceeds 3.
- bypass=1, umi_in_valid=1, data=0xDEAD, umi_out_ready=0 → umi_out_valid=1, umi_out_data=0xDEAD same cycle, umi_in_ready=0, fifo_empty stays 1.
- With UMI_FIFO_CHAOS_EN, chaosmode=1, 1000 packets → umi_in_ready low on some non-full cycles, all packets delivered in order; chaosmode=0 → no stalls when not full.
